vga_bar_display: RTL and testbench

Parametrised VGA timing generator and multi-channel segmented bar-graph renderer. It derives a pixel enable from the system clock and generates hsync and vsync for a configurable mode. It draws N_BARS horizontal level meters, each with a solid outline and lit segments, plus a low-level warning colour. Level inputs are sampled once per frame, so bars never tear. It drives the Basys3 VGA connector directly (4-bit R/G/B).

---
 rtl/vga_bar_display.sv | 165 ++++++++++++++++
 tb/tb_vga_bar_display.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_bar_display.sv
// vga_bar_display
//   VGA timing generator with a segmented multi-channel bar-graph overlay.
//   A clock divider produces a pixel enable (pe). x/y position counters, the
//   sync outputs and the pixel colour all advance on pe. Each bar has a solid
//   two-row outline and an interior that lights one segment per level unit.
//   Levels are clamped and latched once per frame, on the last pixel of the
//   last active line, so the picture never tears mid-frame.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   levels     in   packed levels, bar i = levels[i*LEVEL_W +: LEVEL_W]
//   hsync      out  horizontal sync, active low (registered on pe)
//   vsync      out  vertical sync, active low (registered on pe)
//   r, g, b    out  4-bit colour channels (registered on pe)
//   frame_tick out  one-clk pulse in the clk after the levels are latched
module vga_bar_display #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned N_BARS     = 4,
    parameter int unsigned LEVEL_W    = 5,
    parameter int unsigned SEGS       = 28,
    parameter int unsigned SEG_SHIFT  = 2,
    parameter int unsigned BAR_X0     = 200,
    parameter int unsigned BAR_Y0     = 200,
    parameter int unsigned BAR_H      = 16,
    parameter int unsigned BAR_GAP    = 8,
    parameter int unsigned WARN_LEVEL = 5,
    parameter logic [11:0] FG_COLOR   = 12'hFFF,
    parameter logic [11:0] WARN_COLOR = 12'hF00
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_BARS*LEVEL_W-1:0]   levels,
    output logic                        hsync,
    output logic                        vsync,
    output logic [3:0]                  r,
    output logic [3:0]                  g,
    output logic [3:0]                  b,
    output logic                        frame_tick
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    // A 1-bit divider is kept for CLK_DIV = 1; it then never leaves 0 and pe stays high.
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned BAR_W    = SEGS << SEG_SHIFT;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]    X_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    Y_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    Y_LATCH  = VW'(V_ACTIVE - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               pe;
    logic [HW-1:0]      x;
    logic [VW-1:0]      y;
    logic [LEVEL_W-1:0] shadow [N_BARS];
    logic [11:0]        color;

    logic [31:0]        xi;
    logic [31:0]        yi;
    logic [31:0]        seg;
    logic [31:0]        top;
    logic               in_cols;
    logic               hs_n;
    logic               vs_n;
    logic               latch_pt;
    logic [11:0]        pix_color;

    assign pe = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (pe) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + VW'(1);
            end else begin
                x <= x + HW'(1);
            end
        end
    end

    // Decode of the current (x, y); the result is registered on pe so every
    // output lags the counters by exactly one pixel period.
    always_comb begin
        xi        = 32'(x);
        yi        = 32'(y);
        hs_n      = !((xi >= HS_START) && (xi < HS_END));
        vs_n      = !((yi >= VS_START) && (yi < VS_END));
        latch_pt  = (x == X_LAST) && (y == Y_LATCH);
        in_cols   = (xi >= BAR_X0) && (xi < BAR_X0 + BAR_W);
        seg       = (xi - BAR_X0) >> SEG_SHIFT;
        top       = '0;
        pix_color = '0;
        if ((xi < H_ACTIVE) && (yi < V_ACTIVE) && in_cols) begin
            for (int unsigned i = 0; i < N_BARS; i++) begin
                top = BAR_Y0 + i * (BAR_H + BAR_GAP);
                if ((yi >= top) && (yi < top + BAR_H)) begin
                    if ((yi < top + 2) || (yi >= top + BAR_H - 2)) begin
                        pix_color = FG_COLOR;
                    end else if (seg < 32'(shadow[i])) begin
                        pix_color = (32'(shadow[i]) <= WARN_LEVEL) ? WARN_COLOR : FG_COLOR;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            color      <= '0;
            frame_tick <= 1'b0;
            for (int unsigned i = 0; i < N_BARS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            frame_tick <= pe && latch_pt;
            if (pe) begin
                hsync <= hs_n;
                vsync <= vs_n;
                color <= pix_color;
                if (latch_pt) begin
                    for (int unsigned i = 0; i < N_BARS; i++) begin
                        shadow[i] <= (32'(levels[i*LEVEL_W +: LEVEL_W]) > SEGS)
                                     ? LEVEL_W'(SEGS) : levels[i*LEVEL_W +: LEVEL_W];
                    end
                end
            end
        end
    end

    assign r = color[11:8];
    assign g = color[7:4];
    assign b = color[3:0];

endmodule

// File: tb/tb_vga_bar_display.sv
// tb_vga_bar_display
//   Drives vga_bar_display with a reduced video mode so several whole frames
//   fit in a short run. A reference model tracks the clock count since reset,
//   converts it to a pixel position with plain arithmetic and derives the
//   expected sync levels, colour and frame_tick from the geometric drawing
//   rules. Every clock edge is compared.
module tb_vga_bar_display;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned HA = 48, HF = 4, HS = 6, HB = 6;
    localparam int unsigned VA = 40, VF = 2, VS = 2, VB = 4;
    localparam int unsigned NB = 4, LW = 5, SEGS = 8, SSH = 2;
    localparam int unsigned BX0 = 8, BY0 = 2, BH = 6, BG = 5, WARN = 2;
    localparam logic [11:0] FG = 12'hFFF, WC = 12'hF00;

    localparam int unsigned HT        = HA + HF + HS + HB;
    localparam int unsigned VT        = VA + VF + VS + VB;
    localparam int unsigned FRAME     = HT * VT;
    localparam int unsigned SEGW      = 1 << SSH;
    localparam int unsigned LATCH_PIX = VA * HT - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NB*LW-1:0]  levels = '0;
    logic              hsync, vsync, frame_tick;
    logic [3:0]        r, g, b;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    // reference model state
    int unsigned ce = 0;
    int unsigned sh_m [NB];
    logic        exp_hs = 1'b1;
    logic        exp_vs = 1'b1;
    logic        exp_ft = 1'b0;
    logic [11:0] exp_col = '0;

    always #5 clk = ~clk;

    vga_bar_display #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .N_BARS(NB), .LEVEL_W(LW), .SEGS(SEGS), .SEG_SHIFT(SSH),
        .BAR_X0(BX0), .BAR_Y0(BY0), .BAR_H(BH), .BAR_GAP(BG),
        .WARN_LEVEL(WARN), .FG_COLOR(FG), .WARN_COLOR(WC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .levels(levels),
        .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
        .frame_tick(frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s clk=%0d observed=%0h expected=%0h", tag, ce, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_colour(input int unsigned px, input int unsigned py);
        int unsigned top;
        if (px >= HA || py >= VA) return 12'h000;
        for (int unsigned i = 0; i < NB; i++) begin
            top = BY0 + i * (BH + BG);
            if (py >= top && py < top + BH && px >= BX0 && px < BX0 + SEGS * SEGW) begin
                if (py < top + 2 || py >= top + BH - 2) return FG;
                if ((px - BX0) / SEGW < sh_m[i]) return (sh_m[i] <= WARN) ? WC : FG;
                return 12'h000;
            end
        end
        return 12'h000;
    endfunction

    task automatic reset_model();
        ce      = 0;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
        exp_ft  = 1'b0;
        exp_col = '0;
        for (int i = 0; i < NB; i++) sh_m[i] = 0;
    endtask

    task automatic compare_all();
        check("hsync", 32'(hsync), 32'(exp_hs));
        check("vsync", 32'(vsync), 32'(exp_vs));
        check("rgb", 32'({r, g, b}), 32'(exp_col));
        check("frame_tick", 32'(frame_tick), 32'(exp_ft));
    endtask

    // One clock: advance the model for the edge just taken, then compare.
    task automatic tick();
        int unsigned p, px, py, lv;
        @(posedge clk);
        #1;
        if (rst_n) begin
            ce++;
            exp_ft = 1'b0;
            if (ce % CLK_DIV == 0) begin
                p  = (ce / CLK_DIV - 1) % FRAME;
                px = p % HT;
                py = p / HT;
                exp_hs  = !(px >= HA + HF && px < HA + HF + HS);
                exp_vs  = !(py >= VA + VF && py < VA + VF + VS);
                exp_col = model_colour(px, py);
                if (p == LATCH_PIX) begin
                    exp_ft = 1'b1;
                    for (int i = 0; i < NB; i++) begin
                        lv = 32'(levels[i*LW +: LW]);
                        sh_m[i] = (lv > SEGS) ? SEGS : lv;
                    end
                end
            end
        end
        compare_all();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) tick();
    endtask

    task automatic random_levels();
        for (int i = 0; i < NB; i++) levels[i*LW +: LW] = LW'($urandom_range(0, 31));
    endtask

    initial begin
        int unsigned first_fall;
        int unsigned guard;
        int unsigned target;

        reset_model();
        // bar0 normal, bar1 warning, bar2 over-range (clamps), bar3 full
        levels[0*LW +: LW] = 5'd5;
        levels[1*LW +: LW] = 5'd2;
        levels[2*LW +: LW] = 5'd31;
        levels[3*LW +: LW] = 5'd8;

        run(3);
        @(negedge clk);
        rst_n = 1'b1;

        // Two full frames plus a little: first shows outlines only, second the levels.
        run(2 * FRAME * CLK_DIV + 50);

        // Level changes at arbitrary points, including mid active frame.
        for (int k = 0; k < 12; k++) begin
            random_levels();
            run($urandom_range(400, 3000));
        end
        levels[0*LW +: LW] = 5'd0;
        levels[1*LW +: LW] = 5'd3;
        levels[2*LW +: LW] = 5'd7;
        levels[3*LW +: LW] = 5'd20;
        run(FRAME * CLK_DIV);

        // Stop on the outline row of bar 2 mid-frame, then reset asynchronously.
        target = 24 * HT + 10;
        guard  = 0;
        do begin
            tick();
            guard++;
        end while (!(ce % CLK_DIV == 0 && (ce / CLK_DIV - 1) % FRAME == target)
                   && guard < FRAME * CLK_DIV + 10);
        check("reach_reset_point", 32'(guard < FRAME * CLK_DIV + 10), 32'd1);
        check("pre_reset_rgb", 32'({r, g, b}), 32'(FG));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hsync", 32'(hsync), 32'd1);
        check("async_rst_vsync", 32'(vsync), 32'd1);
        check("async_rst_rgb", 32'({r, g, b}), 32'd0);
        check("async_rst_ft", 32'(frame_tick), 32'd0);
        reset_model();
        run(3);
        @(negedge clk);
        rst_n = 1'b1;

        first_fall = 0;
        for (int unsigned k = 0; k < 2 * HT * CLK_DIV && first_fall == 0; k++) begin
            tick();
            if (hsync === 1'b0) first_fall = ce;
        end
        check("hsync_first_fall_clk", first_fall, CLK_DIV * (HA + HF + 1));

        random_levels();
        run(FRAME * CLK_DIV + FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
